// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV64I instruction fields into 32-bit words and buffers
// them in a 2-entry FIFO with valid/ready handshakes on both sides.
// Optional feature: define INSTR_ENCODER_STATS_EN to add o_instr_count, a
// 16-bit wrapping count of words popped downstream.
module instr_encoder (
    input  logic        i_clk,
    input  logic        i_arstn,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [3:0]  i_type,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic        o_illegal
`ifdef INSTR_ENCODER_STATS_EN
    ,
    output logic [15:0] o_instr_count
`endif
);

    localparam int unsigned InstrW = 32;
    localparam int unsigned Depth  = 2;
`ifdef INSTR_ENCODER_STATS_EN
    localparam int unsigned CountW = 16;
`endif

    // Instruction class codes
    localparam logic [3:0] TypeLoad   = 4'b0000;
    localparam logic [3:0] TypeAluImm = 4'b0001;
    localparam logic [3:0] TypeJalr   = 4'b0010;
    localparam logic [3:0] TypeAluImmW= 4'b0011;
    localparam logic [3:0] TypeStore  = 4'b0100;
    localparam logic [3:0] TypeR      = 4'b0101;
    localparam logic [3:0] TypeRW     = 4'b0110;
    localparam logic [3:0] TypeBranch = 4'b0111;
    localparam logic [3:0] TypeJal    = 4'b1000;
    localparam logic [3:0] TypeAuipc  = 4'b1001;
    localparam logic [3:0] TypeLui    = 4'b1010;

    // Major opcodes
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpAluImm = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpAluImmW= 7'b0011011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpRW     = 7'b0111011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e              state_q, state_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic [InstrW-1:0] instr_q   [Depth];
    logic              illegal_q [Depth];

    logic [InstrW-1:0] enc_instr_c;
    logic              enc_illegal_c;
    logic              push_c;
    logic              pop_c;

    // Combinational field packing for the presented instruction class
    always_comb begin
        enc_instr_c   = '0;
        enc_illegal_c = 1'b0;
        unique case (i_type)
            TypeLoad:
                enc_instr_c = {i_imm[11:0], i_rs1, i_funct3, i_rd, OpLoad};
            TypeAluImm:
                enc_instr_c = {i_imm[11:0], i_rs1, i_funct3, i_rd, OpAluImm};
            TypeJalr:
                enc_instr_c = {i_imm[11:0], i_rs1, 3'b000, i_rd, OpJalr};
            TypeAluImmW:
                enc_instr_c = {i_imm[11:0], i_rs1, i_funct3, i_rd, OpAluImmW};
            TypeStore:
                enc_instr_c = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OpStore};
            TypeR:
                enc_instr_c = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OpR};
            TypeRW:
                enc_instr_c = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OpRW};
            TypeBranch:
                enc_instr_c = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], OpBranch};
            TypeJal:
                enc_instr_c = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                               i_rd, OpJal};
            TypeAuipc:
                enc_instr_c = {i_imm[31:12], i_rd, OpAuipc};
            TypeLui:
                enc_instr_c = {i_imm[31:12], i_rd, OpLui};
            default: begin
                // Unknown classes travel down the stream as a flagged zero word
                enc_instr_c   = '0;
                enc_illegal_c = 1'b1;
            end
        endcase
    end

    assign push_c = i_valid & ready_q;
    assign pop_c  = valid_q & i_ready;

    // Occupancy next-state, pointer advance and registered handshake outputs
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case (state_q)
            EMPTY: if (push_c) state_d = ONE;
            ONE: begin
                if (push_c && !pop_c) begin
                    state_d = FULL;
                end else if (!push_c && pop_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (pop_c) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != FULL);
    end

    // Control state; reset empties the buffer and drops o_valid at once
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    // Storage entries; cleared on reset so the head reads as zero afterwards
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            for (int i = 0; i < int'(Depth); i++) begin
                instr_q[i]   <= '0;
                illegal_q[i] <= 1'b0;
            end
        end else if (push_c) begin
            instr_q[wr_ptr_q]   <= enc_instr_c;
            illegal_q[wr_ptr_q] <= enc_illegal_c;
        end
    end

    assign o_valid   = valid_q;
    assign o_ready   = ready_q;
    assign o_instr   = instr_q[rd_ptr_q];
    assign o_illegal = illegal_q[rd_ptr_q];

`ifdef INSTR_ENCODER_STATS_EN
    logic [CountW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (pop_c) begin
            count_d = count_q + CountW'(1);
        end
    end

    // Wrapping count of words handed downstream
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_instr_count = count_q;
`endif

endmodule
